// File: rtl/serv_ibus_pkg.sv
// Shared definitions for the SERV instruction-bus memory responder.
package serv_ibus_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_READ = 2'd2,
        S_ACK  = 2'd3
    } ibus_state_t;

    // All-zero word decodes as an illegal instruction on RV32.
    localparam logic [31:0] ERR_INSN_DEFAULT = 32'h0000_0000;

    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/serv_ibus_ram.sv
// DEPTH x 32 program RAM: one synchronous read port, one synchronous write
// port, read-before-write on a same-address collision. Array is not reset.
module serv_ibus_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/serv_ibus_mem.sv
// Instruction-bus slave for SERV: answers each fetch with one word and a
// single-cycle ack after WAIT_STATES extra cycles; side port preloads the RAM.
module serv_ibus_mem
    import serv_ibus_pkg::*;
#(
    parameter int          DEPTH       = 256,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] ERR_INSN    = ERR_INSN_DEFAULT
) (
    input  logic                     clk,
    input  logic                     i_rst_n,
    input  logic [31:0]              i_ibus_adr,
    input  logic                     i_ibus_cyc,
    output logic [31:0]              o_ibus_rdt,
    output logic                     o_ibus_ack,
    input  logic                     i_ld_we,
    input  logic [$clog2(DEPTH)-1:0] i_ld_adr,
    input  logic [31:0]              i_ld_dat
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [WAIT_CNT_W-1:0] CNT_LOAD =
        (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

    ibus_state_t           state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic [29:0]           idx_q, idx_d;
    logic                  ack_q, ack_d;
    logic                  oob_q, oob_d;
    logic [31:0]           hold_q, hold_d;
    logic                  ram_re;
    logic [31:0]           ram_rdata;
    logic [31:0]           ack_word;
    logic                  unused_adr_lsb;

    assign unused_adr_lsb = ^i_ibus_adr[1:0];

    serv_ibus_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk     (clk),
        .we_i    (i_ld_we),
        .waddr_i (i_ld_adr),
        .wdata_i (i_ld_dat),
        .re_i    (ram_re),
        .raddr_i (idx_q[AW-1:0]),
        .rdata_o (ram_rdata)
    );

    // RAM data lands in the ACK cycle; hold_q keeps the last word afterwards.
    assign ack_word   = oob_q ? ERR_INSN : ram_rdata;
    assign o_ibus_rdt = (state_q == S_ACK) ? ack_word : hold_q;
    assign o_ibus_ack = ack_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        ack_d   = 1'b0;
        oob_d   = oob_q;
        hold_d  = hold_q;
        ram_re  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (i_ibus_cyc) begin
                    idx_d   = i_ibus_adr[31:2];
                    cnt_d   = CNT_LOAD;
                    state_d = (WAIT_STATES > 0) ? S_WAIT : S_READ;
                end
            end
            S_WAIT: begin
                if (!i_ibus_cyc) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_READ;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_READ: begin
                if (!i_ibus_cyc) begin
                    state_d = S_IDLE;
                end else begin
                    ram_re  = 1'b1;
                    oob_d   = (idx_q >= 30'(DEPTH));
                    ack_d   = 1'b1;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                hold_d  = ack_word;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            ack_q   <= 1'b0;
            oob_q   <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ack_q   <= ack_d;
            oob_q   <= oob_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_serv_ibus_mem.sv
// Directed bench for serv_ibus_mem: three instances with WAIT_STATES 0, 3, 2.
module tb_serv_ibus_mem;

    localparam logic [31:0] ERR = 32'hBADC_0DE5;
    localparam int WS_TAB [3] = '{0, 3, 2};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc    [3];
    logic [31:0] adr    [3];
    logic [31:0] rdt    [3];
    logic        ack    [3];
    logic        ld_we  [3];
    logic [7:0]  ld_adr [3];
    logic [31:0] ld_dat [3];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        serv_ibus_mem #(.DEPTH(256), .WAIT_STATES(WS_TAB[g]), .ERR_INSN(ERR)) u_dut (
            .clk        (clk),
            .i_rst_n    (rst_n),
            .i_ibus_adr (adr[g]),
            .i_ibus_cyc (cyc[g]),
            .o_ibus_rdt (rdt[g]),
            .o_ibus_ack (ack[g]),
            .i_ld_we    (ld_we[g]),
            .i_ld_adr   (ld_adr[g]),
            .i_ld_dat   (ld_dat[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int n, input logic [7:0] a, input logic [31:0] d);
        ld_we[n] = 1'b1; ld_adr[n] = a; ld_dat[n] = d;
        tick();
        ld_we[n] = 1'b0;
    endtask

    // Raise cyc, count edges to ack, check latency/data, drop cyc, check one-shot ack.
    task automatic fetch(input int n, input logic [31:0] a, input int lat,
                         input logic [31:0] exp_rdt, input string name);
        int got;
        got = -1;
        cyc[n] = 1'b1; adr[n] = a;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (ack[n] === 1'b1) begin got = k; break; end
        end
        vectors++;
        if (got !== lat) begin
            miscompares++;
            $display("FAIL %s latency: got %0d cycles, expected %0d", name, got, lat);
        end
        vectors++;
        if (rdt[n] !== exp_rdt) begin
            miscompares++;
            $display("FAIL %s rdt: got %h, expected %h", name, rdt[n], exp_rdt);
        end
        cyc[n] = 1'b0;
        tick();
        vectors++;
        if (ack[n] !== 1'b0) begin
            miscompares++;
            $display("FAIL %s ack_width: ack still %b one cycle later, expected 0", name, ack[n]);
        end
    endtask

    task automatic test_reset();
        for (int n = 0; n < 3; n++) begin
            vectors++;
            if (ack[n] !== 1'b0 || rdt[n] !== 32'h0) begin
                miscompares++;
                $display("FAIL reset[%0d]: ack=%b rdt=%h, expected ack=0 rdt=0", n, ack[n], rdt[n]);
            end
        end
    endtask

    task automatic test_preload();
        for (int n = 0; n < 3; n++) begin
            load(n, 8'd0, 32'h1111_1111);
            load(n, 8'd1, 32'h2222_2222);
            load(n, 8'd2, 32'h3333_3333);
            load(n, 8'd3, 32'h4444_4444);
        end
        load(0, 8'd255, 32'hFFFF_0255);
    endtask

    task automatic test_basic();
        fetch(0, 32'h8, 2, 32'h3333_3333, "ws0_word2");
        fetch(1, 32'h4, 5, 32'h2222_2222, "ws3_word1");
        fetch(2, 32'hC, 4, 32'h4444_4444, "ws2_word3");
    endtask

    task automatic test_range();
        fetch(0, 32'h400,       2, ERR,            "oob_256");
        fetch(0, 32'h3FF,       2, 32'hFFFF_0255,  "word255_lsb_ignored");
        fetch(0, 32'h8000_0004, 2, ERR,            "oob_no_alias");
    endtask

    task automatic test_abort();
        fetch(2, 32'h4, 4, 32'h2222_2222, "abort_setup");
        cyc[2] = 1'b1; adr[2] = 32'h8;
        tick();
        cyc[2] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            vectors++;
            if (ack[2] !== 1'b0 || rdt[2] !== 32'h2222_2222) begin
                miscompares++;
                $display("FAIL abort cycle %0d: ack=%b rdt=%h, expected ack=0 rdt=22222222", k, ack[2], rdt[2]);
            end
        end
        fetch(2, 32'h0, 4, 32'h1111_1111, "after_abort");
    endtask

    task automatic test_back_to_back();
        int got;
        got = -1;
        cyc[1] = 1'b1; adr[1] = 32'h4;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (ack[1] === 1'b1) begin got = k; break; end
        end
        vectors++;
        if (got !== 5) begin
            miscompares++;
            $display("FAIL b2b first latency: got %0d, expected 5", got);
        end
        adr[1] = 32'h8;
        got = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (ack[1] === 1'b1) begin got = k; break; end
        end
        vectors++;
        if (got !== 6 || rdt[1] !== 32'h3333_3333) begin
            miscompares++;
            $display("FAIL b2b period: got %0d cycles rdt=%h, expected 6 cycles rdt=33333333", got, rdt[1]);
        end
        cyc[1] = 1'b0;
        tick();
    endtask

    task automatic test_rbw();
        cyc[0] = 1'b1; adr[0] = 32'h8;
        tick();
        ld_we[0] = 1'b1; ld_adr[0] = 8'd2; ld_dat[0] = 32'hDEAD_BEEF;
        tick();
        ld_we[0] = 1'b0;
        vectors++;
        if (ack[0] !== 1'b1 || rdt[0] !== 32'h3333_3333) begin
            miscompares++;
            $display("FAIL rbw collision: ack=%b rdt=%h, expected ack=1 rdt=33333333", ack[0], rdt[0]);
        end
        cyc[0] = 1'b0;
        tick();
        fetch(0, 32'h8, 2, 32'hDEAD_BEEF, "rbw_new_data");
    endtask

    task automatic test_reset_in_ack();
        cyc[0] = 1'b1; adr[0] = 32'hC;
        tick();
        tick();
        vectors++;
        if (ack[0] !== 1'b1 || rdt[0] !== 32'h4444_4444) begin
            miscompares++;
            $display("FAIL rst_ack pre: ack=%b rdt=%h, expected ack=1 rdt=44444444", ack[0], rdt[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (ack[0] !== 1'b0 || rdt[0] !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_ack async: ack=%b rdt=%h, expected ack=0 rdt=0", ack[0], rdt[0]);
        end
        cyc[0] = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        fetch(0, 32'hC, 2, 32'h4444_4444, "after_reset");
    endtask

    initial begin
        for (int n = 0; n < 3; n++) begin
            cyc[n] = 1'b0; adr[n] = '0; ld_we[n] = 1'b0; ld_adr[n] = '0; ld_dat[n] = '0;
        end
        #12;
        test_reset();
        tick();
        rst_n = 1'b1;
        tick();
        test_preload();
        test_basic();
        test_range();
        test_abort();
        test_back_to_back();
        test_rbw();
        test_reset_in_ack();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
